rebuster_arbiter: RTL and testbench
===================================

// Module: rebuster_arbiter
// PURPOSE
//  Bus arbiter inside rebuster_core. Consumes the clk100-domain cpuclk_rising/cpuclk_falling strobes made by the
//  top-level phase tracker. Arbitrates among the DMAC (SBR_n) and five Zorro masters (EBR_n[4:0]) for the 68030 bus.
//  Negotiates with the CPU via BR_n/BG_n/BGACK_n. Exports the current bus owner to the cycle state machines.
// PARAMETERS
//  GRANT_TIMEOUT   64  cpuclk cycles a granted master may take to assert OWN_n before its grant is withdrawn
//  SBR_FIXED_PRIO  1   1: DMAC beats all Zorro masters; 0: DMAC is slot 5 in the round-robin
// PORTS
//  clk100          in   1  sole clock, 100 MHz, phase-locked to CPUCLK
//  reset_n_in      in   1  asynchronous active-low reset
//  cpuclk_rising   in   1  1-cycle strobe, CPUCLK rising edge
//  cpuclk_falling  in   1  1-cycle strobe, CPUCLK falling edge
//  sbr_n_in        in   1  DMAC bus request, asynchronous
//  ebr_n_in        in   5  Zorro bus requests, asynchronous
//  bg_n_in         in   1  CPU bus grant
//  bgack_n_in      in   1  BGACK_n pin readback
//  as_n_in         in   1  AS_n pin readback
//  own_n_in        in   1  OWN_n pin readback; the master drives it low when it has taken the bus
//  br_n_out/br_n_oe          out 1/1  CPU bus request
//  bgack_n_out/bgack_n_oe    out 1/1  BGACK driven on behalf of the granted master
//  sbg_n_out/sbg_n_oe        out 1/1  DMAC grant
//  ebg_n_out/ebg_n_oe        out 5/5  Zorro grants, one-hot low
//  owner           out  3  0-4 = Zorro slot, 5 = DMAC, 7 = CPU
//  owner_valid     out  1  high while a non-CPU master holds the bus
//  timeout_evt     out  1  1-cycle pulse when a grant is withdrawn by timeout
// BEHAVIOUR
//  Reset (async):
//  - br_n=1, sbg_n=1 and ebg_n=5'h1F are all driven (oe=1); bgack_n_oe=0.
//  - owner=7, owner_valid=0, state IDLE, rr_ptr=0.
//  - Reset asserted mid-grant drops every grant immediately.
//  Input synchronisation and timing:
//  - sbr_n_in, ebr_n_in, bg_n_in, bgack_n_in, as_n_in and own_n_in pass through a 2-flop synchroniser on clk100.
//  - All state transitions happen only on cpuclk_rising. Outputs change in the same clk100 cycle as the transition.
//  - req[5:0] = ~{sbr, ebr[4:0]}, sampled from the synchronised values.
//  States:
//  - IDLE: CPU owns the bus. Go to REQ when any req bit is set.
//  - REQ: br_n=0. Go to WAIT when bg=0.
//      If req falls to 0 first, return to IDLE and set br_n=1.
//  - WAIT: br_n=0. Go to GRANT when as_n=1 and bgack_n_in=1 (bus free).
//      On that same edge, latch winner = pick(req, rr_ptr) and assert its grant.
//  - GRANT: grant held, bgack_n_oe=1 with bgack_n=0, br_n=1, tcnt counts cpuclk cycles.
//      own=0 -> OWN. Winner's request drops -> REL.
//      tcnt==GRANT_TIMEOUT-1 -> REL and pulse timeout_evt.
//  - OWN: owner=winner, owner_valid=1, grant and BGACK held.
//      Go to REL when the winner's request is deasserted AND own=1.
//  - REL: all grants off, bgack_n=1 driven for one cpuclk cycle, then bgack_n_oe=0. rr_ptr = winner+1 mod 6.
//      If req!=0, go to REQ; else go to IDLE.
//  - The CPU always regains the bus between masters; back-to-back grants without an intervening BG are forbidden.
//  Pick rule:
//  - With SBR_FIXED_PRIO=1, req[5] wins outright.
//  - Otherwise: first set bit at or after rr_ptr, wrapping 5->0.
//  - rr_ptr only advances on REL, never on timeout-free IDLE returns.
//  Simultaneous events:
//  - A request arriving during REL is honoured on the next arbitration.
//  - If own=0 and the request drops on the same edge while in GRANT, go to REL.
//  - A cpuclk_falling strobe carries no transitions (reserved, unused inside the block).
//  Exclusivity: at most one of {sbg_n, ebg_n[4:0]} is low at any instant (assertion in TB).
//  tcnt: ceil(log2(GRANT_TIMEOUT)) bits, cleared on entry to GRANT, saturates.
// STRUCTURE
//  - rebuster_defs.vh: state encodings (IDLE, REQ, WAIT, GRANT, OWN, REL), OWNER_CPU=3'd7, OWNER_DMAC=3'd5, NUM_REQ=6.
//  - Sub-module rebuster_rr_pick: combinational 6-way round-robin picker (req, ptr, fixed_prio) -> idx, valid.
//  - Synchronisers are inline.
// TESTING
//  1. ebr_n[2]=0. Expected: br_n=0 on the next cpuclk_rising after sync. BG=0 with AS=1 -> ebg_n=5'b11011, bgack_n=0.
//     Then own=0 -> owner=2, owner_valid=1.
//  2. Grant slot 2, then release ebr_n[2] and own_n. Expected: ebg_n=5'h1F, one cycle of bgack_n=1, oe=0, owner=7, br_n=1.
//  3. ebr_n=5'b00110 with rr_ptr=0: grant to slot 0. After release, slot 3 with rr_ptr=1 gets the next grant.
//  4. sbr_n=0 with ebr_n[0]=0 and SBR_FIXED_PRIO=1. Expected: sbg_n=0, owner=5, no ebg asserted.
//  5. Grant with own_n held high for 64 cpuclk. Expected: timeout_evt pulses, grant removed, rr_ptr advances.
//  6. reset_n low while in OWN. Expected: same clk100 cycle ebg_n=5'h1F, bgack_n_oe=0, br_n=1. Restarts in IDLE.

Source files
------------

// File: rtl/rebuster_arbiter_pkg.sv
// Shared definitions for the rebuster bus arbiter: FSM states, owner codes
// and request-slot helpers.
package rebuster_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_GRANT,
    ST_OWN,
    ST_REL
  } arb_state_t;

  localparam int unsigned NUM_REQ    = 6;
  localparam logic [2:0]  OWNER_CPU  = 3'd7;
  localparam logic [2:0]  OWNER_DMAC = 3'd5;

  // Slot following `slot` in round-robin order, wrapping DMAC (5) back to 0.
  function automatic logic [2:0] next_slot(input logic [2:0] slot);
    return (slot >= 3'(NUM_REQ - 1)) ? 3'd0 : slot + 3'd1;
  endfunction

endpackage

// File: rtl/rebuster_arbiter_rr_pick.sv
// Combinational 6-way round-robin picker; optional fixed priority for the
// DMAC request (slot 5).
module rebuster_rr_pick
  import rebuster_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         ptr,
  input  logic               fixed_prio,
  output logic [2:0]         idx,
  output logic               valid
);

  function automatic logic [2:0] slot_at(input logic [2:0] p, input int unsigned k);
    int unsigned s;
    s = 32'(p) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return 3'(s);
  endfunction

  logic found;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && req[slot_at(ptr, k)]) begin
        idx   = slot_at(ptr, k);
        found = 1'b1;
      end
    end
    if (fixed_prio && req[NUM_REQ-1]) idx = OWNER_DMAC;
    valid = found;
  end

endmodule

// File: rtl/rebuster_arbiter.sv
// 68030 bus arbiter: arbitrates DMAC and five Zorro masters against the CPU
// via BR/BG/BGACK and publishes the current bus owner.
module rebuster_arbiter
  import rebuster_arbiter_pkg::*;
#(
  parameter int unsigned GRANT_TIMEOUT  = 64,
  parameter bit          SBR_FIXED_PRIO = 1'b1
) (
  input  logic       clk100,
  input  logic       reset_n_in,
  input  logic       cpuclk_rising,
  input  logic       cpuclk_falling,
  input  logic       sbr_n_in,
  input  logic [4:0] ebr_n_in,
  input  logic       bg_n_in,
  input  logic       bgack_n_in,
  input  logic       as_n_in,
  input  logic       own_n_in,
  output logic       br_n_out,
  output logic       br_n_oe,
  output logic       bgack_n_out,
  output logic       bgack_n_oe,
  output logic       sbg_n_out,
  output logic       sbg_n_oe,
  output logic [4:0] ebg_n_out,
  output logic [4:0] ebg_n_oe,
  output logic [2:0] owner,
  output logic       owner_valid,
  output logic       timeout_evt
);

  localparam int unsigned TW = (GRANT_TIMEOUT > 1) ? $clog2(GRANT_TIMEOUT) : 1;
  localparam logic [TW-1:0] TCNT_LAST = TW'(GRANT_TIMEOUT - 1);

  // Falling strobe is reserved; no transitions are tied to it.
  logic unused_falling;
  assign unused_falling = cpuclk_falling;

  logic [9:0] sync1, sync2;

  always_ff @(posedge clk100 or negedge reset_n_in) begin
    if (!reset_n_in) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= {sbr_n_in, ebr_n_in, bg_n_in, bgack_n_in, as_n_in, own_n_in};
      sync2 <= sync1;
    end
  end

  logic       sbr_n, bg_n, bgack_n, as_n, own_n;
  logic [4:0] ebr_n;
  assign {sbr_n, ebr_n, bg_n, bgack_n, as_n, own_n} = sync2;

  logic [NUM_REQ-1:0] req;
  assign req = ~{sbr_n, ebr_n};

  arb_state_t    state, state_nxt;
  logic [2:0]    winner, winner_nxt;
  logic [2:0]    rr_ptr, rr_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic          tmo_nxt;
  logic [2:0]    pick_idx;
  logic          pick_valid;
  logic          win_req;

  rebuster_rr_pick u_pick (
    .req        (req),
    .ptr        (rr_ptr),
    .fixed_prio (SBR_FIXED_PRIO),
    .idx        (pick_idx),
    .valid      (pick_valid)
  );

  assign win_req = req[winner];

  always_ff @(posedge clk100 or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state       <= ST_IDLE;
      winner      <= '0;
      rr_ptr      <= '0;
      tcnt        <= '0;
      timeout_evt <= 1'b0;
    end else begin
      state       <= state_nxt;
      winner      <= winner_nxt;
      rr_ptr      <= rr_nxt;
      tcnt        <= tcnt_nxt;
      timeout_evt <= tmo_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    winner_nxt = winner;
    rr_nxt     = rr_ptr;
    tcnt_nxt   = tcnt;
    tmo_nxt    = 1'b0;
    if (cpuclk_rising) begin
      unique case (state)
        ST_IDLE: if (|req) state_nxt = ST_REQ;
        ST_REQ: begin
          if (!(|req))    state_nxt = ST_IDLE;
          else if (!bg_n) state_nxt = ST_WAIT;
        end
        // A requester vanishing after BG has been given hands the bus back.
        ST_WAIT: begin
          if (!pick_valid) begin
            state_nxt = ST_IDLE;
          end else if (as_n && bgack_n) begin
            state_nxt  = ST_GRANT;
            winner_nxt = pick_idx;
            tcnt_nxt   = '0;
          end
        end
        ST_GRANT: begin
          if (!win_req) begin
            state_nxt = ST_REL;
            rr_nxt    = next_slot(winner);
          end else if (!own_n) begin
            state_nxt = ST_OWN;
          end else if (tcnt == TCNT_LAST) begin
            state_nxt = ST_REL;
            rr_nxt    = next_slot(winner);
            tmo_nxt   = 1'b1;
          end else begin
            tcnt_nxt = tcnt + 1'b1;
          end
        end
        ST_OWN: begin
          if (!win_req && own_n) begin
            state_nxt = ST_REL;
            rr_nxt    = next_slot(winner);
          end
        end
        ST_REL:  state_nxt = (|req) ? ST_REQ : ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  logic granted;
  assign granted = (state == ST_GRANT) || (state == ST_OWN);

  always_comb begin
    br_n_oe     = 1'b1;
    sbg_n_oe    = 1'b1;
    ebg_n_oe    = '1;
    br_n_out    = !((state == ST_REQ) || (state == ST_WAIT));
    bgack_n_oe  = granted || (state == ST_REL);
    bgack_n_out = !granted;
    sbg_n_out   = !(granted && (winner == OWNER_DMAC));
    ebg_n_out   = '1;
    for (int unsigned i = 0; i < 5; i++) begin
      ebg_n_out[i] = !(granted && (winner == 3'(i)));
    end
    owner_valid = (state == ST_OWN);
    owner       = (state == ST_OWN) ? winner : OWNER_CPU;
  end

endmodule

// File: tb/tb_rebuster_arbiter.sv
// Directed bench for rebuster_arbiter: scripted vector table plus timeout
// and mid-ownership reset sequences.
module tb_rebuster_arbiter;

  localparam int unsigned GRANT_TIMEOUT = 64;

  logic       clk100     = 1'b0;
  logic       reset_n_in = 1'b0;
  logic [1:0] phase      = '0;
  logic       cpuclk_rising, cpuclk_falling;
  logic       sbr_n_in   = 1'b1;
  logic [4:0] ebr_n_in   = 5'h1F;
  logic       bg_n_in    = 1'b1;
  logic       bgack_n_in = 1'b1;
  logic       as_n_in    = 1'b1;
  logic       own_n_in   = 1'b1;

  logic       br_n_out, br_n_oe, bgack_n_out, bgack_n_oe, sbg_n_out, sbg_n_oe;
  logic [4:0] ebg_n_out, ebg_n_oe;
  logic [2:0] owner;
  logic       owner_valid, timeout_evt;

  int checks   = 0;
  int failures = 0;

  always #5 clk100 = ~clk100;

  // CPUCLK = clk100/4; strobes change on the falling clk100 edge.
  always @(negedge clk100) phase <= phase + 2'd1;
  assign cpuclk_rising  = (phase == 2'd0);
  assign cpuclk_falling = (phase == 2'd2);

  rebuster_arbiter #(
    .GRANT_TIMEOUT  (GRANT_TIMEOUT),
    .SBR_FIXED_PRIO (1'b1)
  ) dut (
    .clk100         (clk100),
    .reset_n_in     (reset_n_in),
    .cpuclk_rising  (cpuclk_rising),
    .cpuclk_falling (cpuclk_falling),
    .sbr_n_in       (sbr_n_in),
    .ebr_n_in       (ebr_n_in),
    .bg_n_in        (bg_n_in),
    .bgack_n_in     (bgack_n_in),
    .as_n_in        (as_n_in),
    .own_n_in       (own_n_in),
    .br_n_out       (br_n_out),
    .br_n_oe        (br_n_oe),
    .bgack_n_out    (bgack_n_out),
    .bgack_n_oe     (bgack_n_oe),
    .sbg_n_out      (sbg_n_out),
    .sbg_n_oe       (sbg_n_oe),
    .ebg_n_out      (ebg_n_out),
    .ebg_n_oe       (ebg_n_oe),
    .owner          (owner),
    .owner_valid    (owner_valid),
    .timeout_evt    (timeout_evt)
  );

  // Observed bundle: {br_n, sbg_n, ebg_n[4:0], bgack_oe, bgack_n, owner, owner_valid, timeout_evt}
  function automatic logic [13:0] obs();
    return {br_n_out, sbg_n_out, ebg_n_out, bgack_n_oe, bgack_n_out, owner, owner_valid, timeout_evt};
  endfunction

  function automatic logic [5:0] grant_bits(input logic [2:0] w);
    logic [5:0] g;
    g = 6'h3F;
    if (w == 3'd5) g[5] = 1'b0;
    else           g[w] = 1'b0;
    return g;
  endfunction

  function automatic logic [13:0] e_idle();
    return {1'b1, 6'h3F, 1'b0, 1'b1, 3'd7, 1'b0, 1'b0};
  endfunction
  function automatic logic [13:0] e_req();
    return {1'b0, 6'h3F, 1'b0, 1'b1, 3'd7, 1'b0, 1'b0};
  endfunction
  function automatic logic [13:0] e_grant(input logic [2:0] w);
    return {1'b1, grant_bits(w), 1'b1, 1'b0, 3'd7, 1'b0, 1'b0};
  endfunction
  function automatic logic [13:0] e_own(input logic [2:0] w);
    return {1'b1, grant_bits(w), 1'b1, 1'b0, w, 1'b1, 1'b0};
  endfunction
  function automatic logic [13:0] e_rel();
    return {1'b1, 6'h3F, 1'b1, 1'b1, 3'd7, 1'b0, 1'b0};
  endfunction

  typedef struct packed {
    logic        sbr_n;
    logic [4:0]  ebr_n;
    logic        bg_n;
    logic        as_n;
    logic        own_n;
    logic [13:0] expv;
  } vec_t;

  vec_t  vecs[$];
  string names[$];

  task automatic addv(input string nm, input logic sbr, input logic [4:0] ebr,
                      input logic bg, input logic as_, input logic own, input logic [13:0] ex);
    vec_t v;
    v.sbr_n = sbr; v.ebr_n = ebr; v.bg_n = bg; v.as_n = as_; v.own_n = own; v.expv = ex;
    vecs.push_back(v);
    names.push_back(nm);
  endtask

  task automatic drive(input logic sbr, input logic [4:0] ebr, input logic bg,
                       input logic as_, input logic own);
    sbr_n_in = sbr; ebr_n_in = ebr; bg_n_in = bg; as_n_in = as_; own_n_in = own;
  endtask

  task automatic check(input string nm, input logic [13:0] got, input logic [13:0] ex);
    checks++;
    if (got !== ex) begin
      failures++;
      $display("FAIL %s got br,sbg,ebg,oe,bgk,own,val,tmo=%b required %b", nm, got, ex);
    end
  endtask

  // Advance to just after the next clk100 edge that carries a cpuclk_rising strobe.
  task automatic rise();
    int n;
    n = 0;
    do begin
      @(posedge clk100);
      n++;
    end while (!cpuclk_rising && n < 8);
    if (!cpuclk_rising) begin
      checks++;
      failures++;
      $display("FAIL rise_wait got no strobe in %0d cycles required strobe", n);
    end
    #1;
  endtask

  always @(negedge clk100) begin
    if (reset_n_in) begin
      checks++;
      if ($countones(~{sbg_n_out, ebg_n_out}) > 1) begin
        failures++;
        $display("FAIL grant_excl got sbg=%b ebg=%b required at most one low", sbg_n_out, ebg_n_out);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got no completion required finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // rr_ptr=0: slots 0,3,4 request -> 0; after release rr_ptr=1 -> 3
    addv("idle",        1, 5'h1F,    1, 1, 1, e_idle());
    addv("t3_req",      1, 5'b00110, 1, 1, 1, e_req());
    addv("t3_wait",     1, 5'b00110, 0, 1, 1, e_req());
    addv("t3_grant0",   1, 5'b00110, 0, 1, 1, e_grant(3'd0));
    addv("t3_own0",     1, 5'b00110, 0, 1, 0, e_own(3'd0));
    addv("t3_rel0",     1, 5'b00111, 1, 1, 1, e_rel());
    addv("t3_rereq",    1, 5'b00111, 1, 1, 1, e_req());
    addv("t3_wait2",    1, 5'b00111, 0, 1, 1, e_req());
    addv("t3_grant3",   1, 5'b00111, 0, 1, 1, e_grant(3'd3));
    addv("t3_own3",     1, 5'b00111, 0, 1, 0, e_own(3'd3));
    addv("t3_rel3",     1, 5'h1F,    1, 1, 1, e_rel());
    addv("t3_idle",     1, 5'h1F,    1, 1, 1, e_idle());
    // request withdrawn before BG: back to IDLE, rr_ptr stays 4
    addv("abort_req",   1, 5'b01111, 1, 1, 1, e_req());
    addv("abort_idle",  1, 5'h1F,    1, 1, 1, e_idle());
    // slot 2 with rr_ptr=4 (wraps)
    addv("t1_req",      1, 5'b11011, 1, 1, 1, e_req());
    addv("t1_wait",     1, 5'b11011, 0, 1, 1, e_req());
    addv("t1_grant2",   1, 5'b11011, 0, 1, 1, e_grant(3'd2));
    addv("t1_own2",     1, 5'b11011, 0, 1, 0, e_own(3'd2));
    addv("t2_hold",     1, 5'h1F,    0, 1, 0, e_own(3'd2));
    addv("t2_rel",      1, 5'h1F,    1, 1, 1, e_rel());
    addv("t2_idle",     1, 5'h1F,    1, 1, 1, e_idle());
    // rr_ptr=3: round-robin would pick 3, fixed priority gives DMAC
    addv("t4_req",      0, 5'b10110, 1, 1, 1, e_req());
    addv("t4_wait",     0, 5'b10110, 0, 1, 1, e_req());
    addv("t4_busy",     0, 5'b10110, 0, 0, 1, e_req());
    addv("t4_grant5",   0, 5'b10110, 0, 1, 1, e_grant(3'd5));
    addv("t4_own5",     0, 5'b10110, 0, 1, 0, e_own(3'd5));
    addv("t4_rel",      1, 5'h1F,    1, 1, 1, e_rel());
    addv("t4_idle",     1, 5'h1F,    1, 1, 1, e_idle());
    // rr_ptr=0: own and request drop on the same edge in GRANT -> REL
    addv("sd_req",      1, 5'b11101, 1, 1, 1, e_req());
    addv("sd_wait",     1, 5'b11101, 0, 1, 1, e_req());
    addv("sd_grant1",   1, 5'b11101, 0, 1, 1, e_grant(3'd1));
    addv("sd_rel",      1, 5'h1F,    1, 1, 0, e_rel());
    addv("sd_idle",     1, 5'h1F,    1, 1, 1, e_idle());

    drive(1, 5'h1F, 1, 1, 1);
    repeat (3) @(posedge clk100);
    #1;
    check("reset", obs(), e_idle());
    @(negedge clk100);
    reset_n_in = 1'b1;
    rise();

    foreach (vecs[i]) begin
      drive(vecs[i].sbr_n, vecs[i].ebr_n, vecs[i].bg_n, vecs[i].as_n, vecs[i].own_n);
      rise();
      check(names[i], obs(), vecs[i].expv);
    end

    // Timeout: rr_ptr=2, slot 3 granted but never asserts OWN
    drive(1, 5'b10111, 1, 1, 1);
    rise();
    check("to_req", obs(), e_req());
    drive(1, 5'b10111, 0, 1, 1);
    rise();
    check("to_wait", obs(), e_req());
    rise();
    check("to_grant3", obs(), e_grant(3'd3));
    for (int i = 1; i < GRANT_TIMEOUT; i++) begin
      rise();
      check("to_hold", obs(), e_grant(3'd3));
    end
    rise();
    check("to_expire", obs(), e_rel() | 14'd1);
    drive(1, 5'b10111, 1, 1, 1);
    @(posedge clk100);
    #1;
    check("to_pulse_end", obs(), e_rel());
    rise();
    check("to_rereq", obs(), e_req());
    // rr_ptr advanced to 4: slots 3 and 4 requesting -> 4
    drive(1, 5'b00111, 0, 1, 1);
    rise();
    check("to_wait2", obs(), e_req());
    rise();
    check("to_grant4", obs(), e_grant(3'd4));
    drive(1, 5'b00111, 0, 1, 0);
    rise();
    check("rst_own4", obs(), e_own(3'd4));

    // Asynchronous reset while in OWN
    @(posedge clk100);
    #3;
    reset_n_in = 1'b0;
    #1;
    check("rst_async", obs(), e_idle());
    drive(1, 5'h1F, 1, 1, 1);
    #20;
    @(negedge clk100);
    reset_n_in = 1'b1;
    rise();
    rise();
    check("rst_idle", obs(), e_idle());
    drive(1, 5'b01111, 1, 1, 1);
    rise();
    check("rst_restart", obs(), e_req());
    drive(1, 5'h1F, 1, 1, 1);
    rise();
    check("rst_final_idle", obs(), e_idle());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
